// File: rtl/inv_mc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inv_mc_pkg : shared types, constants and GF(2^8) helper for inverse MixColumns
// Rev 1.0
// ---------------------------------------------------------------------------
package inv_mc_pkg;

   localparam int           COL_W = 32;
   localparam int           N_COL = 4;
   localparam int           CNT_W = 2;
   localparam logic [7:0]   POLY  = 8'h1B;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Multiply by x in GF(2^8), reducing by POLY on carry-out.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/inv_mixcolumn_col32.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inv_mixcolumn_col32 : combinational inverse MixColumns of one 32-bit column
// Rev 1.0
// ---------------------------------------------------------------------------
module inv_mixcolumn_col32
   import inv_mc_pkg::*;
(
   input  logic [COL_W-1:0] col_i,
   output logic [COL_W-1:0] col_o
);

   logic [3:0][7:0] w_m9;
   logic [3:0][7:0] w_mb;
   logic [3:0][7:0] w_md;
   logic [3:0][7:0] w_me;

   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_byte
         logic [7:0] w_s;
         logic [7:0] w_x2;
         logic [7:0] w_x4;
         logic [7:0] w_x8;

         assign w_s  = col_i[8*i +: 8];
         assign w_x2 = xtime(w_s);
         assign w_x4 = xtime(w_x2);
         assign w_x8 = xtime(w_x4);

         // 09 = 8+1, 0B = 8+2+1, 0D = 8+4+1, 0E = 8+4+2
         assign w_m9[i] = w_x8 ^ w_s;
         assign w_mb[i] = w_x8 ^ w_x2 ^ w_s;
         assign w_md[i] = w_x8 ^ w_x4 ^ w_s;
         assign w_me[i] = w_x8 ^ w_x4 ^ w_x2;

         assign col_o[8*i +: 8] = w_me[i]
                                ^ w_mb[(i+1) % 4]
                                ^ w_md[(i+2) % 4]
                                ^ w_m9[(i+3) % 4];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/inv_mixcolumn_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inv_mixcolumn_serial : column-serial inverse MixColumns, one column per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module inv_mixcolumn_serial
   import inv_mc_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_COL*COL_W-1:0]  in_state,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N_COL*COL_W-1:0]  out_state,
   output logic                    busy
);

   state_t                         state_q;
   logic [CNT_W-1:0]               cnt_q;
   logic [N_COL-1:0][COL_W-1:0]    work_q;
   logic [N_COL-1:0][COL_W-1:0]    work_d;
   logic                           out_valid_q;
   logic                           busy_q;

   logic [COL_W-1:0]               w_col_in;
   logic [COL_W-1:0]               w_col_out;

   assign w_col_in = work_q[cnt_q];

   inv_mixcolumn_col32 u_col (
      .col_i (w_col_in),
      .col_o (w_col_out)
   );

   // Only the column addressed by the counter is rewritten this cycle.
   genvar k;
   generate
      for (k = 0; k < N_COL; k++) begin : g_wb
         assign work_d[k] = (cnt_q == CNT_W'(k)) ? w_col_out : work_q[k];
      end
   endgenerate

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_state = work_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  work_q  <= in_state;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               work_q <= work_d;
               cnt_q  <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(N_COL-1)) begin
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (in_valid) begin
                     work_q  <= in_state;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_BUSY;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q     <= S_IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inv_mixcolumn_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_inv_mixcolumn_serial : self-checking bench with a GF(2^8) reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_inv_mixcolumn_serial;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   localparam logic [127:0] KIN  = {32'hd6d7d5d5, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
   localparam logic [127:0] KOUT = {32'hd5d4d4d4, 32'h01010101, 32'h5c220af2, 32'h455313db};

   inv_mixcolumn_serial dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;
   logic [127:0] exp_q[$];
   logic [127:0] rt_q[$];
   bit rt_mode = 1'b0;

   // Plain shift-and-add product, reduced by the full degree-8 polynomial.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (p[i]) p = p ^ (16'h011B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] coefs);
      logic [7:0] m [4];
      logic [127:0] r;
      logic [7:0] acc;
      for (int j = 0; j < 4; j++) m[j] = coefs[31 - 8*j -: 8];
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(m[(j - row + 4) % 4], s[32*c + 8*j +: 8]);
            r[32*c + 8*row +: 8] = acc;
         end
      return r;
   endfunction

   function automatic logic [127:0] inv_ref(input logic [127:0] s);
      return mix(s, 32'h0E0B0D09);
   endfunction

   function automatic logic [127:0] fwd_ref(input logic [127:0] s);
      return mix(s, 32'h02030101);
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s got %h want %h", name, got, want);
   endtask

   // Scoreboard: expected results queued at accept, compared at output handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         rt_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_output got %h want no output", out_state);
            end else begin
               chk("out_state", out_state, exp_q.pop_front());
               if (rt_mode && rt_q.size() != 0)
                  chk("round_trip", out_state, rt_q.pop_front());
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(inv_ref(in_state));
      end
   end

   task automatic send(input logic [127:0] v, output int t_acc, output logic ov);
      bit ok;
      ok = 1'b0;
      t_acc = 0;
      ov = 1'b0;
      in_valid = 1'b1;
      in_state = v;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            t_acc = cyc;
            ov = out_valid;
         end
         @(posedge clk);
         #1;
         if (ok) break;
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_checks++;
         $display("FAIL accept_timeout got no accept want accept within 50 cycles");
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 100; t++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want completion");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int           t_acc [8];
      logic         ov_acc [8];
      int           ta;
      logic         ov;
      logic [127:0] v;
      logic [127:0] snap;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_state  = '0;

      #2;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy",      128'(busy),      128'(0));
      chk("rst_in_ready",  128'(in_ready),  128'(1));
      chk("rst_out_state", out_state,       128'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Pin the reference model against the published vector.
      chk("model_inv", inv_ref(KIN), KOUT);
      chk("model_fwd", fwd_ref(KOUT), KIN);

      // Known vector with exact latency, then held under backpressure.
      send(KIN, ta, ov);
      chk("e0_busy", 128'(busy), 128'(1));
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk); #1;
         chk($sformatf("latency_e%0d_out_valid", e), 128'(out_valid), 128'(e == 4));
      end
      chk("known_out_state", out_state, KOUT);
      chk("done_busy", 128'(busy), 128'(0));
      snap = out_state;
      for (int t = 0; t < 10; t++) begin
         @(posedge clk); #1;
         chk("bp_out_state", out_state, snap);
         chk("bp_out_valid", 128'(out_valid), 128'(1));
         chk("bp_in_ready",  128'(in_ready),  128'(0));
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      chk("idle_out_valid", 128'(out_valid), 128'(0));
      chk("idle_busy",      128'(busy),      128'(0));
      chk("idle_in_ready",  128'(in_ready),  128'(1));
      drain();

      // New data offered mid-computation must be ignored.
      send(128'h0123456789abcdef_fedcba9876543210, ta, ov);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_state = 128'hdeadbeef_cafef00d_01020304_a5a55a5a;
      chk("drop_busy", 128'(busy), 128'(1));
      chk("drop_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      // Back-to-back stream: one accept every 5 cycles, coincident with output.
      for (int i = 0; i < 8; i++) begin
         v = {$urandom(), $urandom(), $urandom(), 24'h0, 8'(i)};
         send(v, ta, ov);
         t_acc[i]  = ta;
         ov_acc[i] = ov;
      end
      drain();
      for (int i = 1; i < 8; i++) begin
         chk($sformatf("b2b_gap_%0d", i), 128'(t_acc[i] - t_acc[i-1]), 128'(5));
         chk($sformatf("b2b_coincident_%0d", i), 128'(ov_acc[i]), 128'(1));
      end

      // Asynchronous reset two edges into S_BUSY.
      send(KIN, ta, ov);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_busy",      128'(busy),      128'(0));
      chk("mid_rst_in_ready",  128'(in_ready),  128'(1));
      chk("mid_rst_out_state", out_state,       128'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(KIN ^ 128'h1, ta, ov);
      drain();

      // Round trip through the forward mixer.
      rt_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         v = {$urandom(), $urandom(), $urandom(), $urandom()};
         rt_q.push_back(v);
         send(fwd_ref(v), ta, ov);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
